// File: rtl/tictactoe_ctrl.sv
// Tic-tac-toe game controller: cursor tracking, mark placement, win/draw detection.
// Every output is a register. The game phase is held in a PLAY -> CHECK -> OVER state machine.
module tictactoe_ctrl #(
    parameter int CELL_ORIGIN = 70,
    parameter int CELL_PITCH  = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_game,
    input  logic        mv_up,
    input  logic        mv_down,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        place,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic [17:0] square,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        invalid
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t      state, state_d;
    logic [1:0]  row, col, row_d, col_d;
    logic [3:0]  cnt, cnt_d;
    logic [17:0] square_d;
    logic        turn_d, draw_d, invalid_d;
    logic [1:0]  winner_d, line_win_code;
    logic [3:0]  cell_idx;
    logic [1:0]  cells [9];

    // Opposing pulses on the same axis cancel each other.
    function automatic logic [1:0] wrap_step(input logic [1:0] pos, input logic inc, input logic dec);
        if (inc && !dec)
            return (pos == 2'd2) ? 2'd0 : pos + 2'd1;
        else if (dec && !inc)
            return (pos == 2'd0) ? 2'd2 : pos - 2'd1;
        else
            return pos;
    endfunction

    function automatic logic [9:0] pix(input logic [1:0] idx);
        return 10'(CELL_ORIGIN + CELL_PITCH * int'(idx));
    endfunction

    function automatic logic [1:0] same3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
    endfunction

    function automatic logic [1:0] line_win(input logic [17:0] sq);
        logic [1:0] c [9];
        logic [1:0] w;
        for (int i = 0; i < 9; i++) c[i] = sq[17-2*i -: 2];
        w = same3(c[0], c[1], c[2]);
        if (w == 2'b00) w = same3(c[3], c[4], c[5]);
        if (w == 2'b00) w = same3(c[6], c[7], c[8]);
        if (w == 2'b00) w = same3(c[0], c[3], c[6]);
        if (w == 2'b00) w = same3(c[1], c[4], c[7]);
        if (w == 2'b00) w = same3(c[2], c[5], c[8]);
        if (w == 2'b00) w = same3(c[0], c[4], c[8]);
        if (w == 2'b00) w = same3(c[2], c[4], c[6]);
        return w;
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) cells[i] = square[17-2*i -: 2];
        cell_idx      = {2'b00, row} * 4'd3 + {2'b00, col};
        line_win_code = line_win(square);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= PLAY;
            row      <= 2'd0;
            col      <= 2'd0;
            cnt      <= 4'd0;
            square   <= 18'd0;
            turn     <= 1'b0;
            winner   <= 2'b00;
            draw     <= 1'b0;
            invalid  <= 1'b0;
            cursor_x <= pix(2'd0);
            cursor_y <= pix(2'd0);
        end else begin
            state    <= state_d;
            row      <= row_d;
            col      <= col_d;
            cnt      <= cnt_d;
            square   <= square_d;
            turn     <= turn_d;
            winner   <= winner_d;
            draw     <= draw_d;
            invalid  <= invalid_d;
            cursor_x <= pix(col_d);
            cursor_y <= pix(row_d);
        end
    end

    always_comb begin
        state_d = state;
        if (new_game) begin
            state_d = PLAY;
        end else begin
            case (state)
                PLAY:    if (place && cells[cell_idx] == 2'b00) state_d = CHECK;
                CHECK:   state_d = (line_win_code != 2'b00 || cnt == 4'd9) ? OVER : PLAY;
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end
    end

    // Next values of board, turn, result flags and cursor
    always_comb begin
        square_d  = square;
        turn_d    = turn;
        winner_d  = winner;
        draw_d    = draw;
        invalid_d = 1'b0;
        cnt_d     = cnt;
        row_d     = wrap_step(row, mv_down, mv_up);
        col_d     = wrap_step(col, mv_right, mv_left);
        if (new_game) begin
            square_d = 18'd0;
            turn_d   = 1'b0;
            winner_d = 2'b00;
            draw_d   = 1'b0;
            cnt_d    = 4'd0;
            row_d    = 2'd0;
            col_d    = 2'd0;
        end else begin
            case (state)
                PLAY: begin
                    if (place) begin
                        if (cells[cell_idx] == 2'b00) begin
                            for (int i = 0; i < 9; i++)
                                if (4'(i) == cell_idx) square_d[17-2*i -: 2] = turn ? 2'b10 : 2'b01;
                            cnt_d = cnt + 4'd1;
                        end else begin
                            invalid_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    invalid_d = place;
                    if (line_win_code != 2'b00) winner_d = line_win_code;
                    else if (cnt == 4'd9)       draw_d   = 1'b1;
                    else                        turn_d   = ~turn;
                end
                OVER:    invalid_d = place;
                default: invalid_d = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/tictactoe_ctrl.md
TICTACTOE_CTRL -- requirements
Module: tictactoe_ctrl

Interface
REQ-001 SHALL have parameter CELL_ORIGIN, default 70, meaning pixel coordinate of the centre of row/column 0.
REQ-002 SHALL have parameter CELL_PITCH, default 160, meaning pixel distance between adjacent cell centres.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port new_game  input  1  one-cycle pulse; clears board and restarts the game.
REQ-006 SHALL have ports mv_up, mv_down, mv_left, mv_right  input  1 each  one-cycle cursor move pulses, already debounced.
REQ-007 SHALL have port place  input  1  one-cycle pulse; place current player's mark at the cursor cell.
REQ-008 SHALL have port cursor_x  output  10  pixel x of cursor cell centre = CELL_ORIGIN + CELL_PITCH*col.
REQ-009 SHALL have port cursor_y  output  10  pixel y of cursor cell centre = CELL_ORIGIN + CELL_PITCH*row.
REQ-010 SHALL have port square  output  18  packed board; cell (r,c), i=3r+c, occupies bits [17-2i:16-2i]; 00 empty, 01 player 1, 10 player 2.
REQ-011 SHALL have port turn  output  1  0 = player 1 to move, 1 = player 2.
REQ-012 SHALL have port winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-013 SHALL have port draw  output  1  board full with no winner.
REQ-014 SHALL have port invalid  output  1  one-cycle pulse when a place is rejected.

Function
REQ-015 SHALL implement states PLAY, CHECK, OVER; all outputs registered.
REQ-016 Cursor SHALL be held as row, col in 0..2; cursor_x/cursor_y SHALL be derived from them and update in the cycle after a move pulse.
REQ-017 mv_right at col 2 SHALL wrap to col 0; mv_left at col 0 SHALL wrap to col 2; mv_down/mv_up SHALL wrap rows likewise.
REQ-018 mv_up and mv_down asserted together SHALL leave row unchanged; mv_left and mv_right together SHALL leave col unchanged.
REQ-019 Cursor moves SHALL be accepted in all states.
REQ-020 In PLAY, place on an empty cell SHALL write 01 (turn=0) or 10 (turn=1) into that cell, increment the 4-bit mark counter, and enter CHECK next cycle.
REQ-021 In PLAY, place on an occupied cell SHALL leave the board unchanged, stay in PLAY, and pulse invalid for exactly one cycle.
REQ-022 place in CHECK or OVER SHALL be ignored and SHALL pulse invalid.
REQ-023 place and a move pulse in the same cycle SHALL mark the pre-move cursor cell and also apply the move.
REQ-024 CHECK SHALL last exactly one cycle and evaluate 3 rows, 3 columns and 2 diagonals on the registered board.
REQ-025 If a line holds three identical non-zero cells, the next state SHALL be OVER with winner set to that code; turn SHALL be unchanged.
REQ-026 Else, if the mark counter equals 9, the next state SHALL be OVER with draw=1.
REQ-027 Else, turn SHALL toggle and the next state SHALL be PLAY.
REQ-028 A win on the 9th mark SHALL report winner only, with draw=0.
REQ-029 Marks placed SHALL become visible on square one cycle after the place pulse; winner/draw SHALL appear two cycles after it.
REQ-030 OVER SHALL hold board, winner and draw until new_game or reset.
REQ-031 new_game in any state SHALL take priority over place and moves: it clears square, winner, draw, counter, sets turn=0, cursor to (0,0), state PLAY, and clears invalid.

Reset
REQ-032 With reset_n=0 at a clock edge: state=PLAY, square=0, turn=0, winner=00, draw=0, invalid=0, counter=0, cursor (0,0), hence cursor_x=70 and cursor_y=70.
REQ-033 Reset SHALL take priority over new_game and all other inputs, including mid-CHECK.

Verification
REQ-034 After reset, mv_right x2 then mv_down x1 -> cursor_x=390, cursor_y=230; a further mv_right -> cursor_x=70.
REQ-035 place at (0,0) -> square=18'h10000, turn=1 two cycles later; place at (0,0) again -> invalid pulse, square unchanged.
REQ-036 P1 places (0,0),(0,1),(0,2), interleaved with P2 at (1,0),(1,1) -> winner=01 two cycles after the last place, turn=0; a subsequent place -> invalid pulse, board unchanged.
REQ-037 Nine alternating placements forming no line -> draw=1, winner=00; a layout where the 9th mark completes a line -> winner set, draw=0.
REQ-038 Assert new_game together with place and mv_right while in OVER -> square=0, winner=00, draw=0, turn=0, cursor_x=70, state PLAY.
REQ-039 Assert reset_n=0 in the CHECK cycle -> all outputs take reset values next cycle with no winner/draw update.
